// File: rtl/compressor_tree_pkg.sv
// Shared helpers for the pipelined 3:2 compressor tree: reduction schedule
// arithmetic used to size each level at elaboration time.
package compressor_tree_pkg;

  // Enough levels for up to 64 operands (64->43->29->20->14->10->7->5->4->3->2).
  localparam int MAX_LEVELS = 10;

  function automatic int next_terms(input int n);
    return (n / 3) * 2 + n % 3;
  endfunction

  // Number of terms entering level k (k = 1 is the operand level).
  function automatic int level_terms(input int n, input int k);
    int t;
    t = n;
    for (int i = 1; i < MAX_LEVELS + 2; i++) begin
      if (i < k) t = next_terms(t);
    end
    return t;
  endfunction

  // Levels needed to reduce n terms down to a sum/carry pair.
  function automatic int num_levels(input int n);
    int t;
    int l;
    t = n;
    l = 0;
    for (int i = 0; i < MAX_LEVELS; i++) begin
      if (t > 2) begin
        t = next_terms(t);
        l++;
      end
    end
    return l;
  endfunction

endpackage

// File: rtl/carry_save_adder.sv
// Bitwise 3:2 carry-save adder: three words in, sum and unshifted carry out.
module carry_save_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] cout
);

  assign sum  = a ^ b ^ c;
  assign cout = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/csa_level.sv
// One reduction level of the compressor tree: a bank of carry-save adders
// over groups of three terms, pass-through of the 1-2 leftover terms, and
// the registered valid/data stage that follows the level.
module csa_level #(
  parameter int IN_TERMS    = 3,
  parameter int OUT_BIT_LEN = 8,
  localparam int OUT_TERMS  = (IN_TERMS / 3) * 2 + IN_TERMS % 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [IN_TERMS*OUT_BIT_LEN-1:0]  in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [OUT_TERMS*OUT_BIT_LEN-1:0] out_data
);

  localparam int W   = OUT_BIT_LEN;
  localparam int NG  = IN_TERMS / 3;
  localparam int REM = IN_TERMS % 3;

  logic [OUT_TERMS*W-1:0] comb;

  for (genvar g = 0; g < NG; g++) begin : g_csa
    logic [W-1:0] a, b, c;
    logic [W-2:0] s_lo, c_lo;

    assign a = in_data[(3*g)*W +: W];
    assign b = in_data[(3*g+1)*W +: W];
    assign c = in_data[(3*g+2)*W +: W];

    // The MSB column's carry would be shifted out of the word, so only
    // the low W-1 columns need a full adder; the MSB keeps just its sum.
    carry_save_adder #(.WIDTH(W-1)) u_csa (
      .a   (a[W-2:0]),
      .b   (b[W-2:0]),
      .c   (c[W-2:0]),
      .sum (s_lo),
      .cout(c_lo)
    );

    assign comb[(2*g)*W +: W]   = {a[W-1] ^ b[W-1] ^ c[W-1], s_lo};
    assign comb[(2*g+1)*W +: W] = {c_lo, 1'b0};
  end

  if (REM > 0) begin : g_pass
    assign comb[OUT_TERMS*W-1 : 2*NG*W] = in_data[IN_TERMS*W-1 : 3*NG*W];
  end

  // Stage loads when empty or being drained downstream this cycle.
  assign in_ready = !out_valid || out_ready;

  // Valid bit follows upstream on load; data changes only on a real handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= comb;
    end
  end

endmodule

// File: rtl/pipelined_compressor_tree.sv
// Pipelined Wallace tree reducing NUM_ELEMENTS operands to a sum/carry pair
// with valid/ready handshakes and bubble collapsing between levels.
// Optional macro COMPRESSOR_TREE_CPA_EN adds a final carry-propagate stage
// that resolves the pair into a single sum (out_carry then reads zero).
module pipelined_compressor_tree
  import compressor_tree_pkg::*;
#(
  parameter int NUM_ELEMENTS = 9,
  parameter int BIT_LEN      = 19,
  parameter int OUT_BIT_LEN  = BIT_LEN + $clog2(NUM_ELEMENTS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_ELEMENTS*BIT_LEN-1:0] in_terms,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [OUT_BIT_LEN-1:0]          out_sum,
  output logic [OUT_BIT_LEN-1:0]          out_carry
);

  localparam int W = OUT_BIT_LEN;
  localparam int L = num_levels(NUM_ELEMENTS);

  if (NUM_ELEMENTS < 3) begin : g_bad_cfg
    $error("pipelined_compressor_tree: NUM_ELEMENTS must be >= 3");
  end else begin : g_tree
    logic [L:0] vld;
    logic [L:0] rdy;
    logic [NUM_ELEMENTS*W-1:0] ext;
    logic [W-1:0] red_sum;
    logic [W-1:0] red_carry;

    assign vld[0]   = in_valid;
    assign in_ready = rdy[0];

    for (genvar i = 0; i < NUM_ELEMENTS; i++) begin : g_ext
      assign ext[i*W +: W] = {{(W-BIT_LEN){1'b0}}, in_terms[i*BIT_LEN +: BIT_LEN]};
    end

    for (genvar k = 0; k < L; k++) begin : lvl
      localparam int NT = level_terms(NUM_ELEMENTS, k + 1);
      localparam int NO = level_terms(NUM_ELEMENTS, k + 2);
      logic [NT*W-1:0] din;
      logic [NO*W-1:0] dout;

      if (k == 0) begin : g_first
        assign din = ext;
      end else begin : g_next
        assign din = lvl[k-1].dout;
      end

      csa_level #(.IN_TERMS(NT), .OUT_BIT_LEN(W)) u_level (
        .clk      (clk),
        .reset    (reset),
        .in_valid (vld[k]),
        .in_ready (rdy[k]),
        .in_data  (din),
        .out_valid(vld[k+1]),
        .out_ready(rdy[k+1]),
        .out_data (dout)
      );
    end

    assign red_sum   = lvl[L-1].dout[W-1:0];
    assign red_carry = lvl[L-1].dout[2*W-1:W];

`ifdef COMPRESSOR_TREE_CPA_EN
    logic         cpa_valid;
    logic [W-1:0] cpa_sum;

    assign rdy[L] = !cpa_valid || out_ready;

    // Final stage resolves the redundant pair with a carry-propagate add.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cpa_valid <= 1'b0;
        cpa_sum   <= '0;
      end else if (rdy[L]) begin
        cpa_valid <= vld[L];
        if (vld[L]) cpa_sum <= red_sum + red_carry;
      end
    end

    assign out_valid = cpa_valid;
    assign out_sum   = cpa_sum;
    assign out_carry = '0;
`else
    assign rdy[L]    = out_ready;
    assign out_valid = vld[L];
    assign out_sum   = red_sum;
    assign out_carry = red_carry;
`endif
  end

endmodule

// File: tb/tb_pipelined_compressor_tree.sv
// Scoreboard bench for pipelined_compressor_tree: expected sums are pushed on
// every input handshake and popped by a monitor on every output handshake.
module tb_pipelined_compressor_tree;

  localparam int NE = 9;
  localparam int BL = 19;
  localparam int OW = 23;
`ifdef COMPRESSOR_TREE_CPA_EN
  localparam int LAT = 5;
  localparam int L3  = 2;
  localparam int L16 = 7;
`else
  localparam int LAT = 4;
  localparam int L3  = 1;
  localparam int L16 = 6;
`endif

  logic clk = 0;
  logic reset = 1;
  logic in_valid = 0;
  logic out_ready = 1;
  logic in_ready, out_valid;
  logic [NE*BL-1:0] in_terms = '0;
  logic [OW-1:0] out_sum, out_carry;

  logic iv3 = 0, r3, ov3;
  logic [3*BL-1:0] t3 = '0;
  logic [20:0] s3, c3;
  logic iv16 = 0, r16, ov16;
  logic [16*BL-1:0] t16 = '0;
  logic [22:0] s16, c16;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [OW-1:0] exp;
    int            acc;
    bit            lat;
  } sb_item_t;
  sb_item_t sb[$];

  pipelined_compressor_tree #(.NUM_ELEMENTS(NE), .BIT_LEN(BL)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_terms(in_terms), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_carry(out_carry));

  pipelined_compressor_tree #(.NUM_ELEMENTS(3), .BIT_LEN(BL)) dut3 (
    .clk(clk), .reset(reset), .in_valid(iv3), .in_ready(r3),
    .in_terms(t3), .out_valid(ov3), .out_ready(1'b1),
    .out_sum(s3), .out_carry(c3));

  pipelined_compressor_tree #(.NUM_ELEMENTS(16), .BIT_LEN(BL)) dut16 (
    .clk(clk), .reset(reset), .in_valid(iv16), .in_ready(r16),
    .in_terms(t16), .out_valid(ov16), .out_ready(1'b1),
    .out_sum(s16), .out_carry(c16));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain sum of the first n operands, reduced mod 2^obl.
  function automatic logic [63:0] ref_sum(input logic [16*BL-1:0] t, input int n, input int obl);
    logic [63:0] s;
    s = 0;
    for (int i = 0; i < n; i++) s += 64'(t[i*BL +: BL]);
    return s & ((64'd1 << obl) - 1);
  endfunction

  function automatic logic [63:0] ref9(input logic [NE*BL-1:0] t);
    logic [16*BL-1:0] p;
    p = '0;
    p[NE*BL-1:0] = t;
    return ref_sum(p, NE, OW);
  endfunction

  function automatic logic [16*BL-1:0] rand_terms();
    logic [16*BL-1:0] p;
    for (int i = 0; i < 16; i++) p[i*BL +: BL] = BL'($urandom);
    return p;
  endfunction

  function automatic logic [16*BL-1:0] alt_terms();
    logic [16*BL-1:0] p;
    for (int i = 0; i < 16; i++) p[i*BL +: BL] = (i % 2 == 1) ? {BL{1'b1}} : '0;
    return p;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Present a set and hold it until accepted; the expectation is queued at acceptance.
  task automatic send(input logic [NE*BL-1:0] t, input logic [OW-1:0] exp, input bit lat,
                      output int waits);
    sb_item_t it;
    waits = 0;
    @(posedge clk); #1;
    in_valid = 1;
    in_terms = t;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        it.exp = exp; it.acc = cyc + 1; it.lat = lat;
        sb.push_back(it);
        break;
      end
      waits++;
      if (waits > 200) begin
        checks++; errors++;
        $display("FAIL send_timeout: in_ready stuck at %0b, required 1", in_ready);
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 64'(sb.size()), 0);
  endtask

  // Monitor: compare on output handshake and check hold-under-stall.
  logic prev_stall = 0;
  logic [OW-1:0] p_sum, p_carry;
  always @(negedge clk) begin
    sb_item_t e;
    logic [OW-1:0] got;
    if (reset) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!out_valid || out_sum !== p_sum || out_carry !== p_carry) begin
          errors++;
          $display("FAIL stall_hold: got v=%0b s=%0h c=%0h required v=1 s=%0h c=%0h",
                   out_valid, out_sum, out_carry, p_sum, p_carry);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got s=%0h c=%0h required no output", out_sum, out_carry);
        end else begin
          e = sb.pop_front();
          got = out_sum + out_carry;
          if (got !== e.exp) begin
            errors++;
            $display("FAIL result: got %0h required %0h", got, e.exp);
          end
          if (e.lat) begin
            checks++;
            if (cyc + 1 - e.acc != LAT) begin
              errors++;
              $display("FAIL latency: got %0d required %0d", cyc + 1 - e.acc, LAT);
            end
          end
`ifdef COMPRESSOR_TREE_CPA_EN
          checks++;
          if (out_carry !== '0) begin
            errors++;
            $display("FAIL cpa_carry_zero: got %0h required 0", out_carry);
          end
`endif
        end
      end
      prev_stall = out_valid && !out_ready;
      p_sum = out_sum;
      p_carry = out_carry;
    end
  end

  task automatic run3(input logic [16*BL-1:0] p);
    int n;
    logic [20:0] got;
    @(posedge clk); #1;
    iv3 = 1; t3 = p[3*BL-1:0];
    @(negedge clk);
    chk("n3_in_ready", 64'(r3), 1);
    @(posedge clk); #1;
    iv3 = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!ov3 && n < 20);
    chk("n3_latency", 64'(n), 64'(L3));
    got = s3 + c3;
    chk("n3_sum", 64'(got), ref_sum(p, 3, 21));
  endtask

  task automatic run16(input logic [16*BL-1:0] p);
    int n;
    logic [22:0] got;
    @(posedge clk); #1;
    iv16 = 1; t16 = p;
    @(negedge clk);
    chk("n16_in_ready", 64'(r16), 1);
    @(posedge clk); #1;
    iv16 = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!ov16 && n < 20);
    chk("n16_latency", 64'(n), 64'(L16));
    got = s16 + c16;
    chk("n16_sum", 64'(got), ref_sum(p, 16, 23));
  endtask

  initial begin
    int w;
    int drops;
    bit done;
    logic [NE*BL-1:0] t;

    // Reset state
    #12;
    chk("rst_in_ready", 64'(in_ready), 1);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_sum", 64'(out_sum), 0);
    chk("rst_out_carry", 64'(out_carry), 0);
    @(negedge clk);
    reset = 0;

    // All operands at maximum
    out_ready = 1;
    t = {NE{19'h7FFFF}};
    send(t, 23'h47FFF7, 1, w);
    idle(1);
    drain();

    // Back-to-back random sets
    drops = 0;
    for (int i = 0; i < 100; i++) begin
      t = NE*BL'(rand_terms());
      send(t, OW'(ref9(t)), 1, w);
      if (w != 0) drops++;
    end
    idle(1);
    chk("b2b_ready_drops", 64'(drops), 0);
    drain();

    // Backpressure: fill every stage, then hold
    out_ready = 0;
    for (int i = 0; i < LAT; i++) begin
      t = NE*BL'(rand_terms());
      send(t, OW'(ref9(t)), 0, w);
    end
    idle(1);
    @(negedge clk);
    chk("full_in_ready", 64'(in_ready), 0);
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    out_ready = 1;
    drain();

    // Bubble collapse: gaps between sets still fill the stalled pipe
    out_ready = 0;
    t = NE*BL'(rand_terms());
    send(t, OW'(ref9(t)), 0, w);
    idle(2);
    for (int i = 1; i < LAT; i++) begin
      t = NE*BL'(rand_terms());
      send(t, OW'(ref9(t)), 0, w);
      chk("bubble_accept_wait", 64'(w), 0);
    end
    idle(1);
    @(negedge clk);
    chk("bubble_full_in_ready", 64'(in_ready), 0);
    @(posedge clk); #1;
    out_ready = 1;
    drain();

    // Random traffic with random backpressure
    done = 0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          t = NE*BL'(rand_terms());
          send(t, OW'(ref9(t)), 0, w);
          idle($urandom_range(0, 2));
        end
        idle(1);
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1;
    drain();

    // Asynchronous reset flushes in-flight sets
    for (int i = 0; i < 3; i++) begin
      t = NE*BL'(rand_terms());
      send(t, OW'(ref9(t)), 0, w);
    end
    idle(2);
    #2;
    reset = 1;
    #1;
    sb.delete();
    chk("arst_out_valid", 64'(out_valid), 0);
    chk("arst_out_sum", 64'(out_sum), 0);
    chk("arst_out_carry", 64'(out_carry), 0);
    chk("arst_in_ready", 64'(in_ready), 1);
    @(negedge clk);
    reset = 0;
    repeat (LAT + 3) @(negedge clk);
    chk("post_reset_quiet", 64'(out_valid), 0);

    // Smallest and larger tree builds
    run3(alt_terms());
    run3(rand_terms());
    run16(alt_terms());
    run16(rand_terms());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
